// File: rtl/linescanner_pkg.sv
// Shared types and widths for the line-scan sensor emulator.
package linescanner_pkg;

    localparam int DATA_W     = 8;
    localparam int LINE_CNT_W = 16;
    localparam int PIX_W      = 16;
    localparam int ADC_CNT_W  = 8;

    typedef enum logic [1:0] {
        ADC_IDLE,
        ADC_CONVERT,
        ADC_DONE
    } adc_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_ACTIVE
    } rd_state_t;

    // Test pattern: each line is a ramp offset by its line index, wrapping mod 256.
    function automatic logic [DATA_W-1:0] pixel_value(input logic [DATA_W-1:0] line_idx,
                                                      input logic [PIX_W-1:0]  pix);
        return line_idx + pix[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/linescanner_sensor_emulator_if.sv
// Sensor-side control/readout signals; master = capture unit, slave = sensor.
interface linescanner_sensor_emulator_if;

    logic                             rst_cvc;
    logic                             rst_cds;
    logic                             sample;
    logic                             load_pulse;
    logic [linescanner_pkg::DATA_W-1:0] data;
    logic                             lval;
    logic                             end_adc;

    modport master (
        output rst_cvc, rst_cds, sample, load_pulse,
        input  data, lval, end_adc
    );

    modport slave (
        input  rst_cvc, rst_cds, sample, load_pulse,
        output data, lval, end_adc
    );

endinterface

// File: rtl/linescanner_readout_gen.sv
// Readout FSM: streams PIXELS_PER_LINE pattern pixels with lval after a start strobe.
module linescanner_readout_gen
    import linescanner_pkg::*;
#(
    parameter int PIXELS_PER_LINE = 1024
) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] line_idx,
    output logic [DATA_W-1:0] data,
    output logic              lval,
    output logic              busy
);

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXELS_PER_LINE - 1);

    rd_state_t         state;
    rd_state_t         state_next;
    logic [PIX_W-1:0]  pix;
    logic [DATA_W-1:0] idx;
    logic              last_pix;

    assign last_pix = (pix == LAST_PIX);

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Line index is captured once at start so a later line_count change cannot corrupt the line.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            pix <= '0;
            idx <= '0;
        end else if (state == RD_IDLE) begin
            pix <= '0;
            if (start) begin
                idx <= line_idx;
            end
        end else begin
            pix <= pix + PIX_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RD_IDLE:   if (start)    state_next = RD_ACTIVE;
            RD_ACTIVE: if (last_pix) state_next = RD_IDLE;
            default:                 state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RD_ACTIVE);
        lval = busy;
        data = busy ? pixel_value(idx, pix) : '0;
    end

endmodule

// File: rtl/linescanner_sensor_emulator.sv
// Line-scan sensor emulator: sample edge detect, ADC timing FSM, line counter, readout.
// Optional LINESCAN_EMU_PROTO_CHECK_EN enables the sticky protocol_error detector.
module linescanner_sensor_emulator
    import linescanner_pkg::*;
#(
    parameter int PIXELS_PER_LINE = 1024,
    parameter int ADC_CYCLES      = 16
) (
    input  logic                          pixel_clock,
    input  logic                          reset,
    input  logic                          enable,
    linescanner_sensor_emulator_if.slave  sensor,
    output logic [LINE_CNT_W-1:0]         line_count,
    output logic                          protocol_error
);

    localparam logic [ADC_CNT_W-1:0] ADC_LAST = ADC_CNT_W'(ADC_CYCLES - 1);

    adc_state_t           adc_state;
    adc_state_t           adc_next;
    logic [ADC_CNT_W-1:0] adc_count;
    logic                 sample_q;
    logic                 load_q;
    logic                 trigger;
    logic                 load_rise;
    logic                 load_accept;
    logic                 rd_busy;

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            sample_q <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            sample_q <= sensor.sample;
            load_q   <= sensor.load_pulse;
        end
    end

    // Only the first cycle of a load pulse can be accepted; held-high cycles are ignored.
    always_comb begin
        trigger     = sample_q & ~sensor.sample & ~sensor.rst_cvc & ~sensor.rst_cds;
        load_rise   = sensor.load_pulse & ~load_q;
        load_accept = load_rise & (adc_state == ADC_DONE) & ~rd_busy;
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            adc_state <= ADC_IDLE;
        end else begin
            adc_state <= adc_next;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            adc_count <= '0;
        end else if (adc_state == ADC_CONVERT) begin
            adc_count <= adc_count + ADC_CNT_W'(1);
        end else begin
            adc_count <= '0;
        end
    end

    always_comb begin
        adc_next = adc_state;
        case (adc_state)
            ADC_IDLE:    if (trigger && enable)       adc_next = ADC_CONVERT;
            ADC_CONVERT: if (adc_count == ADC_LAST)   adc_next = ADC_DONE;
            ADC_DONE:    if (load_accept)             adc_next = ADC_IDLE;
            default:                                  adc_next = ADC_IDLE;
        endcase
    end

    always_comb begin
        sensor.end_adc = (adc_state == ADC_DONE);
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            line_count <= '0;
        end else if (load_accept) begin
            line_count <= line_count + LINE_CNT_W'(1);
        end
    end

    linescanner_readout_gen #(
        .PIXELS_PER_LINE (PIXELS_PER_LINE)
    ) readout (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .start       (load_accept),
        .line_idx    (line_count[DATA_W-1:0]),
        .data        (sensor.data),
        .lval        (sensor.lval),
        .busy        (rd_busy)
    );

`ifdef LINESCAN_EMU_PROTO_CHECK_EN
    logic violation;

    always_comb begin
        violation = (trigger && (adc_state != ADC_IDLE))
                 || (load_rise && (adc_state != ADC_DONE))
                 || (load_rise && (adc_state == ADC_DONE) && rd_busy)
                 || (sensor.load_pulse && load_q);
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            protocol_error <= 1'b0;
        end else if (violation) begin
            protocol_error <= 1'b1;
        end
    end
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_linescanner_sensor_emulator.sv
// Randomized self-checking bench for linescanner_sensor_emulator (8 pixels, 4 ADC cycles).
module tb_linescanner_sensor_emulator;

    localparam int PPL = 8;
    localparam int ADC = 4;
`ifdef LINESCAN_EMU_PROTO_CHECK_EN
    localparam bit PROTO_EN = 1'b1;
`else
    localparam bit PROTO_EN = 1'b0;
`endif

    logic        pixel_clock;
    logic        reset;
    logic        enable;
    logic [15:0] line_count;
    logic        protocol_error;

    int compared   = 0;
    int mismatched = 0;
    int exp_lines  = 0;

    linescanner_sensor_emulator_if sif ();

    linescanner_sensor_emulator #(
        .PIXELS_PER_LINE (PPL),
        .ADC_CYCLES      (ADC)
    ) dut (
        .pixel_clock    (pixel_clock),
        .reset          (reset),
        .enable         (enable),
        .sensor         (sif),
        .line_count     (line_count),
        .protocol_error (protocol_error)
    );

    initial begin
        pixel_clock = 1'b0;
        forever #5 pixel_clock = ~pixel_clock;
    end

    task automatic step();
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic fire_trigger();
        sif.sample = 1'b1;
        step();
        sif.sample = 1'b0;
        step();
    endtask

    // Start a conversion and expect end_adc to rise exactly ADC cycles after the trigger edge.
    task automatic convert_and_wait();
        int hold;
        fire_trigger();
        for (int k = 1; k <= ADC; k++) begin
            step();
            compared++;
            if (sif.end_adc !== (k == ADC)) begin
                mismatched++;
                $display("[TB] FAIL adc_latency k=%0d: got %0b expected %0b", k, sif.end_adc, (k == ADC));
            end
        end
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
            step();
            compared++;
            if (sif.end_adc !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL end_adc_hold: got %0b expected 1", sif.end_adc);
            end
        end
    endtask

    task automatic load_and_read();
        int idx;
        logic [7:0] exp_data;
        idx = exp_lines % 256;
        sif.load_pulse = 1'b1;
        step();
        sif.load_pulse = 1'b0;
        exp_lines++;
        compared++;
        if (sif.end_adc !== 1'b0 || line_count !== 16'(exp_lines)) begin
            mismatched++;
            $display("[TB] FAIL load_accept: got end_adc=%0b count=%0d expected end_adc=0 count=%0d",
                     sif.end_adc, line_count, 16'(exp_lines));
        end
        for (int p = 0; p < PPL; p++) begin
            exp_data = 8'((idx + p) % 256);
            compared++;
            if (sif.lval !== 1'b1 || sif.data !== exp_data) begin
                mismatched++;
                $display("[TB] FAIL pixel %0d: got lval=%0b data=%02h expected lval=1 data=%02h",
                         p, sif.lval, sif.data, exp_data);
            end
            step();
        end
        compared++;
        if (sif.lval !== 1'b0 || sif.data !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL line_end: got lval=%0b data=%02h expected lval=0 data=00", sif.lval, sif.data);
        end
    endtask

    task automatic random_gap();
        int gap;
        gap = $urandom_range(0, 4);
        for (int g = 0; g < gap; g++) step();
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        enable         = 1'b1;
        sif.rst_cvc    = 1'b0;
        sif.rst_cds    = 1'b0;
        sif.sample     = 1'b0;
        sif.load_pulse = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_lines = 0;
        compared++;
        if (sif.data !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got %02h expected 00", sif.data);
        end
        compared++;
        if (sif.lval !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_lval: got %0b expected 0", sif.lval);
        end
        compared++;
        if (sif.end_adc !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_end_adc: got %0b expected 0", sif.end_adc);
        end
        compared++;
        if (line_count !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL reset_line_count: got %0d expected 0", line_count);
        end
        compared++;
        if (protocol_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_error: got %0b expected 0", protocol_error);
        end
    endtask

    task automatic test_full_line();
        convert_and_wait();
        load_and_read();
        random_gap();
        convert_and_wait();
        load_and_read();
        compared++;
        if (protocol_error !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_line_error: got %0b expected 0", protocol_error);
        end
    endtask

    task automatic test_overlap();
        int idx;
        logic [7:0] exp_data;
        convert_and_wait();
        idx = exp_lines % 256;
        sif.load_pulse = 1'b1;
        step();
        sif.load_pulse = 1'b0;
        exp_lines++;
        for (int c = 0; c < PPL; c++) begin
            exp_data = 8'((idx + c) % 256);
            compared++;
            if (sif.lval !== 1'b1 || sif.data !== exp_data || sif.end_adc !== (c >= 6)) begin
                mismatched++;
                $display("[TB] FAIL overlap_pix %0d: got lval=%0b data=%02h end_adc=%0b expected 1 %02h %0b",
                         c, sif.lval, sif.data, sif.end_adc, exp_data, (c >= 6));
            end
            sif.sample     = (c == 0);
            sif.load_pulse = (c == 6);
            step();
        end
        sif.sample     = 1'b0;
        sif.load_pulse = 1'b0;
        compared++;
        if (sif.lval !== 1'b0 || sif.end_adc !== 1'b1 || line_count !== 16'(exp_lines)) begin
            mismatched++;
            $display("[TB] FAIL overlap_ignored: got lval=%0b end_adc=%0b count=%0d expected 0 1 %0d",
                     sif.lval, sif.end_adc, line_count, 16'(exp_lines));
        end
        compared++;
        if (protocol_error !== PROTO_EN) begin
            mismatched++;
            $display("[TB] FAIL overlap_error: got %0b expected %0b", protocol_error, PROTO_EN);
        end
        random_gap();
        load_and_read();
    endtask

    task automatic test_gating();
        int mode;
        for (int i = 0; i < 6; i++) begin
            mode = $urandom_range(0, 2);
            sif.rst_cds = (mode == 0);
            sif.rst_cvc = (mode == 1);
            enable      = (mode != 2);
            fire_trigger();
            for (int k = 0; k <= ADC; k++) step();
            compared++;
            if (sif.end_adc !== 1'b0 || protocol_error !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL gating mode=%0d: got end_adc=%0b err=%0b expected 0 0",
                         mode, sif.end_adc, protocol_error);
            end
            sif.rst_cds = 1'b0;
            sif.rst_cvc = 1'b0;
            enable      = 1'b1;
            step();
        end
        convert_and_wait();
        load_and_read();
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 256; n++) begin
            convert_and_wait();
            load_and_read();
            random_gap();
        end
    endtask

    task automatic test_abuse();
        sif.load_pulse = 1'b1;
        step();
        sif.load_pulse = 1'b0;
        step();
        compared++;
        if (sif.lval !== 1'b0 || line_count !== 16'h0000 || sif.end_adc !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_load: got lval=%0b count=%0d end_adc=%0b expected 0 0 0",
                     sif.lval, line_count, sif.end_adc);
        end
        compared++;
        if (protocol_error !== PROTO_EN) begin
            mismatched++;
            $display("[TB] FAIL idle_load_error: got %0b expected %0b", protocol_error, PROTO_EN);
        end
    endtask

    task automatic test_long_load();
        convert_and_wait();
        sif.load_pulse = 1'b1;
        step();
        step();
        sif.load_pulse = 1'b0;
        exp_lines++;
        compared++;
        if (line_count !== 16'(exp_lines) || sif.lval !== 1'b1 || sif.data !== 8'(exp_lines % 256)) begin
            mismatched++;
            $display("[TB] FAIL long_load: got count=%0d lval=%0b data=%02h expected %0d 1 %02h",
                     line_count, sif.lval, sif.data, 16'(exp_lines), 8'(exp_lines % 256));
        end
        compared++;
        if (protocol_error !== PROTO_EN) begin
            mismatched++;
            $display("[TB] FAIL long_load_error: got %0b expected %0b", protocol_error, PROTO_EN);
        end
        for (int p = 0; p < PPL; p++) step();
    endtask

    task automatic test_reset_mid_line();
        int idx;
        convert_and_wait();
        idx = exp_lines % 256;
        sif.load_pulse = 1'b1;
        step();
        sif.load_pulse = 1'b0;
        exp_lines++;
        for (int c = 0; c < 3; c++) begin
            sif.sample = (c == 0);
            step();
        end
        compared++;
        if (sif.data !== 8'((idx + 3) % 256)) begin
            mismatched++;
            $display("[TB] FAIL pixel3: got %02h expected %02h", sif.data, 8'((idx + 3) % 256));
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_lines = 0;
        compared++;
        if (sif.lval !== 1'b0 || sif.data !== 8'h00 || sif.end_adc !== 1'b0 || line_count !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got lval=%0b data=%02h end_adc=%0b count=%0d expected 0 00 0 0",
                     sif.lval, sif.data, sif.end_adc, line_count);
        end
        for (int k = 0; k < ADC + 2; k++) step();
        compared++;
        if (sif.end_adc !== 1'b0 || sif.lval !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL aborted_conversion: got end_adc=%0b lval=%0b expected 0 0",
                     sif.end_adc, sif.lval);
        end
    endtask

    initial begin
        $display("[TB] start, protocol check build = %0b", PROTO_EN);
        test_reset();
        test_full_line();
        test_overlap();
        test_reset();
        test_gating();
        test_wrap();
        test_reset();
        test_abuse();
        test_reset();
        test_long_load();
        test_reset();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
